// File: rtl/one_unit_mul2_seq.sv
// Streaming NxN fixed-point matrix squarer with one signed MAC per cycle.
// Elements arrive and leave row-major over valid/ready; bypass mode echoes the matrix.
module one_unit_mul2_seq #(
   parameter int unsigned N    = 4,
   parameter int unsigned W    = 26,
   parameter int unsigned FRAC = 13
) (
   input  logic         clk_mul,
   input  logic         rstn_mul,
   input  logic         en_mul,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy,
   output logic         ovf
);

   localparam int unsigned NN = N * N;
   localparam int unsigned IW = $clog2(NN);
   localparam int unsigned CW = $clog2(N);
   localparam int unsigned AW = 2 * W + CW;

   localparam logic signed [AW-1:0] SatMax = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] SatMin = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [W-1:0]         MaxW   = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]         MinW   = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StLoad, StCalc, StEmit} state_e;

   state_e                state_q;
   logic                  mode_q;
   logic [IW-1:0]         in_idx_q;
   logic [CW-1:0]         row_q;
   logic [CW-1:0]         col_q;
   logic [CW-1:0]         k_q;
   logic signed [AW-1:0]  acc_q;
   logic [W-1:0]          data_q;
   logic                  last_q;
   logic                  ovf_q;
   logic [W-1:0]          mem_q [NN];

   logic                  in_xfer;
   logic                  out_xfer;
   logic [IW-1:0]         wr_idx;
   logic [IW-1:0]         a_idx;
   logic [IW-1:0]         b_idx;
   logic signed [W-1:0]   op_a;
   logic signed [W-1:0]   op_b;
   logic signed [2*W-1:0] prod;
   logic signed [AW-1:0]  prod_ext;
   logic signed [AW-1:0]  sum;
   logic signed [AW-1:0]  shifted;
   logic                  sat_hi;
   logic                  sat_lo;
   logic [W-1:0]          res;
   logic                  col_end;
   logic [CW-1:0]         nxt_row;
   logic [CW-1:0]         nxt_col;
   logic [IW-1:0]         nxt_idx;
   logic                  nxt_last;

   // Outputs are forced low while reset is held, even before the first reset edge.
   always_comb begin
      in_ready  = rstn_mul & ((state_q == StIdle) | (state_q == StLoad));
      out_valid = rstn_mul & (state_q == StEmit);
      out_last  = out_valid & last_q;
      busy      = rstn_mul & (state_q != StIdle);
      ovf       = rstn_mul & ovf_q;
      out_data  = rstn_mul ? data_q : '0;
   end

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;
   assign wr_idx   = (state_q == StIdle) ? '0 : in_idx_q;

   always_comb begin
      a_idx    = IW'(row_q) * IW'(N) + IW'(k_q);
      b_idx    = IW'(k_q) * IW'(N) + IW'(col_q);
      op_a     = mem_q[a_idx];
      op_b     = mem_q[b_idx];
      prod     = op_a * op_b;
      prod_ext = {{CW{prod[2*W-1]}}, prod};
      sum      = acc_q + prod_ext;
      shifted  = sum >>> FRAC;
      sat_hi   = shifted > SatMax;
      sat_lo   = shifted < SatMin;
      if (sat_hi) begin
         res = MaxW;
      end else if (sat_lo) begin
         res = MinW;
      end else begin
         res = shifted[W-1:0];
      end
   end

   always_comb begin
      col_end  = col_q == CW'(N - 1);
      nxt_col  = col_end ? '0 : col_q + CW'(1);
      nxt_row  = col_end ? row_q + CW'(1) : row_q;
      nxt_idx  = IW'(nxt_row) * IW'(N) + IW'(nxt_col);
      nxt_last = (nxt_row == CW'(N - 1)) & (nxt_col == CW'(N - 1));
   end

   // Element storage carries no reset; it is fully rewritten by every matrix.
   always_ff @(posedge clk_mul) begin
      if (in_xfer) begin
         mem_q[wr_idx] <= in_data;
      end
   end

   always_ff @(posedge clk_mul) begin
      if (!rstn_mul) begin
         state_q  <= StIdle;
         mode_q   <= 1'b0;
         in_idx_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_xfer) begin
                  mode_q   <= en_mul;
                  ovf_q    <= 1'b0;
                  in_idx_q <= IW'(1);
                  state_q  <= StLoad;
               end
            end
            StLoad: begin
               if (in_xfer) begin
                  if (in_idx_q == IW'(NN - 1)) begin
                     in_idx_q <= '0;
                     row_q    <= '0;
                     col_q    <= '0;
                     k_q      <= '0;
                     acc_q    <= '0;
                     if (mode_q) begin
                        state_q <= StCalc;
                     end else begin
                        data_q  <= mem_q[0];
                        last_q  <= 1'b0;
                        state_q <= StEmit;
                     end
                  end else begin
                     in_idx_q <= in_idx_q + IW'(1);
                  end
               end
            end
            StCalc: begin
               if (k_q == CW'(N - 1)) begin
                  k_q     <= '0;
                  acc_q   <= '0;
                  data_q  <= res;
                  last_q  <= (row_q == CW'(N - 1)) & col_end;
                  state_q <= StEmit;
                  if (sat_hi || sat_lo) begin
                     ovf_q <= 1'b1;
                  end
               end else begin
                  k_q   <= k_q + CW'(1);
                  acc_q <= sum;
               end
            end
            StEmit: begin
               if (out_xfer) begin
                  if (last_q) begin
                     state_q <= StIdle;
                  end else begin
                     row_q <= nxt_row;
                     col_q <= nxt_col;
                     if (mode_q) begin
                        state_q <= StCalc;
                     end else begin
                        data_q <= mem_q[nxt_idx];
                        last_q <= nxt_last;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_one_unit_mul2_seq.sv
// Directed and randomized checks of one_unit_mul2_seq against an arithmetic
// matrix-square model (N=4, W=26, FRAC=13).
module tb_one_unit_mul2_seq;

   localparam int N    = 4;
   localparam int W    = 26;
   localparam int FRAC = 13;
   localparam int NN   = N * N;
   localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (W - 1));

   logic         clk = 1'b0;
   logic         rstn_mul;
   logic         en_mul;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;
   logic         ovf;

   int     cyc = 0;
   int     xfer_cyc;
   int     nchk = 0;
   int     nfail = 0;
   longint a [NN];
   longint expv [NN];
   bit     exp_ovf;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   one_unit_mul2_seq #(.N(N), .W(W), .FRAC(FRAC)) dut (
      .clk_mul   (clk),
      .rstn_mul  (rstn_mul),
      .en_mul    (en_mul),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .ovf       (ovf)
   );

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp_v);
      nchk++;
      assert (obs === exp_v) else begin
         nfail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic abort(input string tag);
      nchk++;
      nfail++;
      $display("FAIL %s: timed out", tag);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   endtask

   // Reference: plain integer matrix product, floor shift, clamp.
   task automatic model(input bit sq);
      exp_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            longint s;
            if (!sq) begin
               s = a[i*N+j];
            end else begin
               s = 0;
               for (int k = 0; k < N; k++) s += a[i*N+k] * a[k*N+j];
               s = s >>> FRAC;
               if (s > MAXV) begin
                  s = MAXV;
                  exp_ovf = 1'b1;
               end else if (s < MINV) begin
                  s = MINV;
                  exp_ovf = 1'b1;
               end
            end
            expv[i*N+j] = s;
         end
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_in_ready"},  in_ready,  0);
      check({pfx, "_out_valid"}, out_valid, 0);
      check({pfx, "_out_last"},  out_last,  0);
      check({pfx, "_busy"},      busy,      0);
      check({pfx, "_ovf"},       ovf,       0);
      check({pfx, "_out_data"},  out_data,  0);
   endtask

   // en_mul is only honoured on the first beat; later beats drive the opposite value.
   task automatic push_matrix(input bit sq, input bit gaps);
      logic [63:0] tmp;
      int guard;
      for (int idx = 0; idx < NN; idx++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            en_mul   = ~sq;
            @(posedge clk); #1;
         end
         tmp      = a[idx];
         in_valid = 1'b1;
         in_data  = tmp[W-1:0];
         en_mul   = (idx == 0) ? sq : ~sq;
         guard    = 0;
         while (!in_ready) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 50) abort("in_ready");
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      xfer_cyc = cyc;
   endtask

   task automatic pop_matrix(input int bp_beat, input int exp_lat);
      logic [W-1:0] d0;
      logic         l0;
      int guard;
      guard = 0;
      while (!out_valid) begin
         @(posedge clk); #1;
         guard++;
         if (guard > 100) abort("first_out_valid");
      end
      if (exp_lat > 0) check("latency", cyc - xfer_cyc + 1, exp_lat);
      for (int b = 0; b < NN; b++) begin
         guard = 0;
         while (!out_valid) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 50) abort($sformatf("out_valid[%0d]", b));
         end
         if (b == bp_beat) begin
            out_ready = 1'b0;
            d0 = out_data;
            l0 = out_last;
            repeat (5) begin
               @(posedge clk); #1;
               check("bp_valid", out_valid, 1);
               check("bp_data", out_data, d0);
               check("bp_last", out_last, l0);
            end
            out_ready = 1'b1;
         end
         check($sformatf("data[%0d]", b), $signed(out_data), expv[b]);
         check($sformatf("last[%0d]", b), out_last, (b == NN - 1));
         @(posedge clk); #1;
      end
      check("ovf", ovf, exp_ovf);
      check("busy_after", busy, 0);
   endtask

   task automatic run_matrix(input bit sq, input bit gaps, input int bp_beat,
                             input int exp_lat);
      model(sq);
      push_matrix(sq, gaps);
      pop_matrix(bp_beat, exp_lat);
   endtask

   task automatic load_identity();
      for (int i = 0; i < NN; i++) a[i] = (i / N == i % N) ? 8192 : 0;
   endtask

   task automatic load_random(input int amp);
      for (int i = 0; i < NN; i++) a[i] = longint'($urandom_range(0, 2 * amp)) - amp;
   endtask

   initial begin
      int seen;
      rstn_mul  = 1'b0;
      en_mul    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rstn_mul = 1'b1;
      @(posedge clk); #1;
      check("rel_in_ready", in_ready, 1);

      load_identity();
      run_matrix(1'b1, 1'b0, -1, 5);

      for (int i = 0; i < NN; i++) a[i] = 8192;
      run_matrix(1'b1, 1'b0, -1, 5);

      for (int i = 0; i < NN; i++) a[i] = i + 1;
      run_matrix(1'b0, 1'b0, -1, 1);

      for (int i = 0; i < NN; i++) a[i] = MAXV;
      run_matrix(1'b1, 1'b0, -1, 5);

      for (int i = 0; i < NN; i++) a[i] = 0;
      a[1] = MAXV;
      a[N] = MINV;
      run_matrix(1'b1, 1'b0, -1, 5);

      load_random(20000);
      run_matrix(1'b1, 1'b0, 2, 5);

      // Reset in the middle of CALC must drop the matrix entirely.
      load_identity();
      push_matrix(1'b1, 1'b0);
      @(posedge clk); #1;
      rstn_mul = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("midcalc");
      rstn_mul = 1'b1;
      @(posedge clk); #1;
      check("midcalc_in_ready", in_ready, 1);
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("midcalc_no_stale", seen, 0);
      run_matrix(1'b1, 1'b0, -1, 5);

      for (int r = 0; r < 6; r++) begin
         load_random((r < 3) ? 20000 : (1 << (15 + r)));
         run_matrix(1'($urandom_range(0, 1)), 1'b1, (r % 2 == 0) ? int'($urandom_range(0, NN - 1)) : -1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/one_unit_mul2_seq.md
ONE_UNIT_MUL2_SEQ -- requirements
Module: one_unit_mul2_seq

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension, legal 2..8.
REQ-002 SHALL have parameter W, default 26, signed element width.
REQ-003 SHALL have parameter FRAC, default 13, fractional bits of each element, FRAC < W.
REQ-004 SHALL have the following ports; the design has one clock, and reset is synchronous and active-low:
- clk_mul  in  1  sole clock, rising edge.
- rstn_mul  in  1  reset, synchronous, active-low.
- en_mul  in  1  mode: 1 = square the matrix, 0 = bypass; sampled on the first accepted input beat.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts input element.
- in_data  in  W  signed element; row-major, element (0,0) first.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts output element.
- out_data  out  W  signed result element, row-major.
- out_last  out  1  marks element (N-1,N-1).
- busy  out  1  high in every state except IDLE.
- ovf  out  1  sticky saturation flag for the current matrix.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, CALC, EMIT.
REQ-006 SHALL assert in_ready only in IDLE and LOAD.
REQ-007 SHALL treat a beat as transferred only when valid and ready are both high in the same cycle.
REQ-008 On a transfer in IDLE, the block SHALL store the element at index 0, latch en_mul as the mode, clear ovf, and enter LOAD.
REQ-009 In LOAD, the block SHALL store each transferred element at the next row-major index; with in_valid low it SHALL hold state.
REQ-010 On transfer of element N*N-1, the block SHALL enter CALC if the mode is square, else EMIT.
REQ-011 In square mode, CALC SHALL compute result(i,j) = sum over k of A(i,k)*A(k,j) with one signed multiply-accumulate per cycle, k = 0..N-1.
REQ-012 CALC SHALL take exactly N cycles, then enter EMIT with out_valid high in the following cycle.
REQ-013 The accumulator SHALL be 2W+ceil(log2 N) bits wide and SHALL be cleared at the start of each element.
REQ-014 Result scaling SHALL be an arithmetic right shift of the accumulator by FRAC, i.e. truncation toward minus infinity.
REQ-015 The scaled result SHALL saturate to [-2^(W-1), 2^(W-1)-1]; any saturation SHALL set ovf.
REQ-016 In bypass mode, EMIT SHALL present the stored elements unchanged in row-major order, with no CALC cycles.
REQ-017 In EMIT, out_valid SHALL be high, and out_data and out_last SHALL stay stable until the output transfer.
REQ-018 On an output transfer of a non-last element, the block SHALL go to CALC for the next element in square mode, or stay in EMIT with the next element in bypass mode.
REQ-019 On an output transfer with out_last high, the block SHALL return to IDLE; ovf SHALL hold its value until the next matrix's first input transfer.
REQ-020 Changes on en_mul after the first beat SHALL have no effect on the current matrix.
REQ-021 When out_valid is low, out_data SHALL hold its last value.

Reset
REQ-022 With rstn_mul low at a clock edge, the block SHALL enter IDLE and clear the index counters and accumulator.
REQ-023 While rstn_mul is low, in_ready, out_valid, out_last, busy, ovf, and out_data SHALL all be 0.
REQ-024 The storage array is not required to be reset.
REQ-025 A reset in any state, including mid-CALC or mid-EMIT, SHALL abandon the matrix, and no further output beats of it SHALL appear.
REQ-026 The first cycle after reset release SHALL have in_ready = 1.

Verification (N=4, W=26, FRAC=13)
REQ-027 Identity matrix (diagonal 8192, others 0), en_mul=1 -> 16 outputs equal to the identity, ovf=0, out_last only on beat 16.
REQ-028 Matrix of all 8192, en_mul=1 -> every output is 32768; first out_valid comes 5 cycles after the last input transfer.
REQ-029 en_mul=0 with inputs 1..16 -> outputs 1..16 unchanged, first out_valid the cycle after the last input transfer.
REQ-030 Positive saturation: all elements 2^25-1 -> every output 33554431, ovf=1.
REQ-031 Negative saturation: A(0,1)=2^25-1, A(1,0)=-2^25, others 0 -> output (0,0) = -33554432, ovf=1.
REQ-032 Backpressure: out_ready low for 5 cycles on beat 3 -> out_data and out_last are stable and no beat is lost.
REQ-033 Reset asserted mid-CALC -> all outputs 0; after release, a new identity matrix yields the correct result.
